// File: rtl/mips_cpu_pc_seq.sv
// Purpose : program-counter sequencer with one architectural branch-delay slot,
//           stall hold, three target modes, halt-on-jump-to-HALT_ADDR and a
//           sticky misaligned-target flag.
// Latency : a request seen on advance edge n takes effect on the next advance
//           edge (PC = P+4, then T); link_addr is combinational from PC.
// Backpressure: stall (or updatePC low) freezes PC and all state; requests are
//           sampled only on advancing edges, so control must hold them.
// Ports   : clk, RESET (async active-low); HALT, updatePC, stall;
//           jump_r/reg_jump_value, jump_const/PCOffset, jump_imm/jump_index;
//           outputs PC, link_addr, in_delay_slot, active, addr_err.
module mips_cpu_pc_seq #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = WIDTH'(32'hBFC00000),
  parameter logic [WIDTH-1:0]  HALT_ADDR    = '0
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              HALT,
  input  logic              updatePC,
  input  logic              stall,
  input  logic              jump_r,
  input  logic [WIDTH-1:0]  reg_jump_value,
  input  logic              jump_const,
  input  logic [WIDTH-1:0]  PCOffset,
  input  logic              jump_imm,
  input  logic [25:0]       jump_index,
  output logic [WIDTH-1:0]  PC,
  output logic [WIDTH-1:0]  link_addr,
  output logic              in_delay_slot,
  output logic              active,
  output logic              addr_err
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DELAY,
    ST_HALTED
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             err_q, err_d;

  logic             advance;
  logic             req;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] tgt_rel;
  logic [WIDTH-1:0] tgt_abs;
  logic [WIDTH-1:0] tgt_sel;
  logic [27:0]      idx_bytes;

  assign pc_plus4  = pc_q + WIDTH'(4);
  assign tgt_rel   = pc_plus4 + PCOffset;
  assign idx_bytes = {jump_index, 2'b00};

  // J-type target keeps the upper bits of the delay-slot address; narrow
  // configurations simply take the low bits of the shifted index.
  generate
    if (WIDTH > 28) begin : g_abs_wide
      assign tgt_abs = {pc_plus4[WIDTH-1:28], idx_bytes};
    end else begin : g_abs_narrow
      assign tgt_abs = idx_bytes[WIDTH-1:0];
    end
  endgenerate

  assign req     = jump_r | jump_const | jump_imm;
  assign advance = updatePC & ~stall & (state_q != ST_HALTED);

  always_comb begin
    tgt_sel = tgt_abs;
    if (jump_r)          tgt_sel = reg_jump_value;
    else if (jump_const) tgt_sel = tgt_rel;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    err_d   = err_q;

    if (HALT && state_q != ST_HALTED) begin
      // External halt wins over stall, update and any pending target.
      state_d = ST_HALTED;
      pc_d    = HALT_ADDR;
      tgt_d   = '0;
    end else if (advance) begin
      unique case (state_q)
        ST_RUN: begin
          pc_d = pc_plus4;
          if (req) begin
            tgt_d   = tgt_sel;
            state_d = ST_DELAY;
            if (tgt_sel[1:0] != 2'b00) err_d = 1'b1;
          end
        end
        ST_DELAY: begin
          // Requests raised in the delay slot are dropped.
          if (tgt_q[1:0] != 2'b00) begin
            state_d = ST_HALTED;
            pc_d    = HALT_ADDR;
          end else begin
            pc_d    = tgt_q;
            state_d = (tgt_q == HALT_ADDR) ? ST_HALTED : ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
    end
  end

  assign PC            = pc_q;
  assign link_addr     = pc_q + WIDTH'(8);
  assign in_delay_slot = (state_q == ST_DELAY);
  assign active        = (state_q != ST_HALTED);
  assign addr_err      = err_q;

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
module tb_mips_cpu_pc_seq;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] HA = 32'h00000000;

  logic        clk = 1'b0;
  logic        RESET;
  logic        HALT, updatePC, stall;
  logic        jump_r, jump_const, jump_imm;
  logic [31:0] reg_jump_value, PCOffset;
  logic [25:0] jump_index;
  logic [31:0] PC, link_addr;
  logic        in_delay_slot, active, addr_err;

  mips_cpu_pc_seq dut (
    .clk(clk), .RESET(RESET), .HALT(HALT), .updatePC(updatePC), .stall(stall),
    .jump_r(jump_r), .reg_jump_value(reg_jump_value),
    .jump_const(jump_const), .PCOffset(PCOffset),
    .jump_imm(jump_imm), .jump_index(jump_index),
    .PC(PC), .link_addr(link_addr), .in_delay_slot(in_delay_slot),
    .active(active), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: a queue holding at most one pending branch target; a non-empty
  // queue means the instruction at PC is a delay slot.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_halted;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_target();
    logic [31:0] nxt;
    nxt = m_pc + 32'd4;
    if (jump_r)     return reg_jump_value;
    if (jump_const) return nxt + PCOffset;
    return (nxt & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
  endfunction

  task automatic model_reset();
    m_pc = RV;
    m_pend.delete();
    m_halted = 0;
    m_err = 0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    if (m_halted) return;
    if (HALT) begin
      m_halted = 1;
      m_pc = HA;
      m_pend.delete();
      return;
    end
    if (!updatePC || stall) return;
    if (m_pend.size() != 0) begin
      t = m_pend.pop_front();
      if (t % 4 != 0) begin
        m_halted = 1;
        m_pc = HA;
      end else begin
        m_pc = t;
        if (t == HA) m_halted = 1;
      end
    end else begin
      if (jump_r || jump_const || jump_imm) begin
        t = ref_target();
        m_pend.push_back(t);
        if (t % 4 != 0) m_err = 1;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".pc"},   PC,        m_pc);
    chk({tag, ".link"}, link_addr, m_pc + 32'd8);
    chk({tag, ".ds"},   {31'd0, in_delay_slot}, {31'd0, m_pend.size() != 0});
    chk({tag, ".act"},  {31'd0, active},   {31'd0, !m_halted});
    chk({tag, ".err"},  {31'd0, addr_err}, {31'd0, m_err});
  endtask

  task automatic idle();
    HALT = 0; updatePC = 0; stall = 0;
    jump_r = 0; jump_const = 0; jump_imm = 0;
  endtask

  // One clock: model advances with the same inputs the DUT sees at the edge.
  task automatic step(input string tag);
    model_step();
    @(posedge clk); #1;
    cmp_all(tag);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); updatePC = 1; step("adv");
    end
    idle();
  endtask

  task automatic do_reset();
    RESET = 0; #1;
    model_reset();
    cmp_all("rst");
    @(posedge clk); #1;
    RESET = 1;
  endtask

  initial begin
    idle();
    reg_jump_value = '0; PCOffset = '0; jump_index = '0;
    RESET = 1;
    #2;
    do_reset();
    chk("rst_pc", PC, 32'hBFC00000);
    chk("rst_link", link_addr, 32'hBFC00008);

    // Sequential advance.
    adv(1); chk("seq1", PC, 32'hBFC00004);
    adv(2); chk("seq3", PC, 32'hBFC0000C);
    adv(1); chk("seq4", PC, 32'hBFC00010);

    // Misaligned register jump halts after the delay slot.
    idle(); updatePC = 1; jump_r = 1; reg_jump_value = 32'h00DD1234 + 32'd2;
    reg_jump_value = 32'h00DD1236;
    step("mis_req");
    chk("mis_err", {31'd0, addr_err}, 32'd1);
    chk("mis_ds_pc", PC, 32'hBFC00014);
    adv(1);
    chk("mis_pc", PC, 32'h0);
    chk("mis_act", {31'd0, active}, 32'd0);

    // Aligned register jump.
    do_reset(); adv(4);
    idle(); updatePC = 1; jump_r = 1; reg_jump_value = 32'h00DD1230; step("jr_req");
    chk("jr_ds", PC, 32'hBFC00014);
    adv(1); chk("jr_tgt", PC, 32'h00DD1230);
    adv(1); chk("jr_next", PC, 32'h00DD1234);

    // Backward relative branch; J in delay slot dropped.
    do_reset();
    idle(); updatePC = 1; jump_r = 1; reg_jump_value = 32'h00400000; step("to4m");
    adv(1); chk("at4m", PC, 32'h00400000);
    idle(); updatePC = 1; jump_const = 1; PCOffset = 32'hFFFFFFF8; step("br_req");
    chk("br_ds", PC, 32'h00400004);
    idle(); updatePC = 1; jump_imm = 1; jump_index = 26'h3FFFFFF; step("br_slot");
    chk("br_tgt", PC, 32'h003FFFFC);
    chk("br_ds_clr", {31'd0, in_delay_slot}, 32'd0);

    // Absolute jump with a 3-cycle stall in the delay slot.
    do_reset(); adv(8);
    idle(); updatePC = 1; jump_imm = 1; jump_index = 26'h0000040; step("j_req");
    for (int i = 0; i < 3; i++) begin
      idle(); updatePC = 1; stall = 1; step("j_stall");
      chk("j_hold", PC, 32'hBFC00024);
    end
    adv(1); chk("j_tgt", PC, 32'hB0000100);

    // Jump to the halt address.
    do_reset();
    idle(); updatePC = 1; jump_r = 1; reg_jump_value = 32'h0; step("z_req");
    adv(1); chk("z_act", {31'd0, active}, 32'd0);
    adv(3); chk("z_hold", PC, 32'h0);

    // HALT with stall mid-delay-slot.
    do_reset();
    idle(); updatePC = 1; jump_r = 1; reg_jump_value = 32'h00001000; step("h_req");
    idle(); HALT = 1; stall = 1; updatePC = 1; step("h_halt");
    chk("h_pc", PC, 32'h0);
    chk("h_act", {31'd0, active}, 32'd0);

    // Reset mid-delay-slot acts immediately.
    do_reset();
    idle(); updatePC = 1; jump_r = 1; reg_jump_value = 32'h00001000; step("r_req");
    idle();
    do_reset();
    chk("r_pc", PC, 32'hBFC00000);
    chk("r_ds", {31'd0, in_delay_slot}, 32'd0);
    adv(2); chk("r_after", PC, 32'hBFC00008);

    // Randomized run against the reference.
    for (int i = 0; i < 600; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        idle(); do_reset();
      end else begin
        HALT       = ($urandom_range(0, 99) == 0);
        updatePC   = ($urandom_range(0, 3) != 0);
        stall      = ($urandom_range(0, 4) == 0);
        jump_r     = ($urandom_range(0, 6) == 0);
        jump_const = ($urandom_range(0, 6) == 0);
        jump_imm   = ($urandom_range(0, 6) == 0);
        case ($urandom_range(0, 9))
          0:       reg_jump_value = 32'h0;
          1:       reg_jump_value = $urandom() | 32'd1;
          default: reg_jump_value = $urandom() & 32'hFFFF_FFFC;
        endcase
        PCOffset   = ($urandom_range(0, 9) == 0) ? 32'd6 : ($urandom() & 32'h0000_0FFC) - 32'h800;
        jump_index = 26'($urandom());
        step("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
